cmp_result_tx: RTL and testbench

- Consumer side of the comparator result interface (CMP_Out / CMP_flag).
- Captures each new comparator result and buffers it.
- Serialises the result LSB-first into bytes on a valid/ready byte stream that feeds the UART transmitter.
- Sits between the comparator unit and the TX path in the system datapath.

---
 rtl/cmp_result_tx_pkg.sv | 24 ++
 rtl/cmp_result_tx_edge_det.sv | 22 ++
 rtl/cmp_result_tx.sv | 130 +++++++++++++
 tb/tb_cmp_result_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_result_tx_pkg.sv
// Shared definitions for the comparator result TX path.
//   BYTE_W     : width of one serial byte on the TX stream
//   state_e    : sender state encoding (IDLE / SEND)
//   cmp_func_e : comparator function codes carried alongside results
//   cnt_w()    : counter width for a byte index, never narrower than 1 bit
package cmp_result_tx_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_EQ   = 2'b01,
    CMP_GT   = 2'b10,
    CMP_LT   = 2'b11
  } cmp_func_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cmp_result_tx_edge_det.sv
// Rising-edge detector for the comparator result-valid level.
//   CLK    : clock
//   RST    : synchronous active-high reset
//   flag_i : level input (CMP_flag)
//   rise_o : one-cycle pulse when flag_i is high and was low last cycle
module cmp_result_tx_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic flag_i,
  output logic rise_o
);
  logic flag_q, flag_d;

  always_comb flag_d = flag_i;

  always_ff @(posedge CLK) begin
    if (RST) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign rise_o = flag_i & ~flag_q;
endmodule

// File: rtl/cmp_result_tx.sv
// Captures comparator results and serialises them LSB byte first onto a
// valid/ready byte stream. One result is in flight (shift register) and one
// more can wait in a hold register; anything beyond that is dropped and
// flagged on the sticky OVF.
//   CLK, RST       : clock, synchronous active-high reset
//   CMP_Out        : comparator result word
//   CMP_flag       : result-valid level, captured on its rising edge
//   TX_READY       : downstream accepts TX_DATA this cycle
//   CLR_OVF        : clears OVF (a simultaneous drop wins)
//   TX_DATA        : current byte
//   TX_VALID       : TX_DATA valid (pure state decode)
//   BUSY           : sending or hold register occupied
//   OVF            : sticky, a result was dropped
module cmp_result_tx
  import cmp_result_tx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] CMP_Out,
  input  logic             CMP_flag,
  input  logic             TX_READY,
  input  logic             CLR_OVF,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  output logic             BUSY,
  output logic             OVF
);
  localparam int BYTES = WIDTH / BYTE_W;
  localparam int CNT_W = cnt_w(BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic cap, hs, last, drop;

  cmp_result_tx_edge_det u_edge_det (
    .CLK    (CLK),
    .RST    (RST),
    .flag_i (CMP_flag),
    .rise_o (cap)
  );

  assign hs   = (state_q == ST_SEND) & TX_READY;
  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    cnt_d      = cnt_q;
    drop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cap) begin
          shift_d = CMP_Out;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      default: begin
        if (hs && last) begin
          if (hold_vld_q) begin
            // Reload straight from hold so the next word follows with no gap;
            // a capture this cycle lands in the hold slot just freed.
            shift_d    = hold_q;
            cnt_d      = '0;
            hold_d     = '0;
            hold_vld_d = 1'b0;
            if (cap) begin
              hold_d     = CMP_Out;
              hold_vld_d = 1'b1;
            end
          end else if (cap) begin
            shift_d = CMP_Out;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (hs) begin
            shift_d = shift_q >> BYTE_W;
            cnt_d   = cnt_q + 1'b1;
          end
          if (cap) begin
            if (!hold_vld_q) begin
              hold_d     = CMP_Out;
              hold_vld_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
    endcase

    ovf_d = drop | (ovf_q & ~CLR_OVF);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign TX_VALID = (state_q == ST_SEND);
  assign TX_DATA  = TX_VALID ? shift_q[7:0] : 8'h00;
  assign BUSY     = TX_VALID | hold_vld_q;
  assign OVF      = ovf_q;
endmodule

// File: tb/tb_cmp_result_tx.sv
module tb_cmp_result_tx;
  localparam int W  = 16;
  localparam int NB = W / 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] CMP_Out = '0;
  logic         CMP_flag = 1'b0;
  logic         TX_READY = 1'b0;
  logic         CLR_OVF = 1'b0;
  logic [7:0]   TX_DATA;
  logic         TX_VALID, BUSY, OVF;

  int n_chk = 0;
  int n_fail = 0;

  cmp_result_tx #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .CMP_Out(CMP_Out), .CMP_flag(CMP_flag),
    .TX_READY(TX_READY), .CLR_OVF(CLR_OVF), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of at most two pending words plus the index of
  // the byte currently offered. A word leaves when its last byte is taken; a
  // new result is accepted only if fewer than two words remain afterwards.
  logic [W-1:0] mq[$];
  int           mb = 0;
  logic         m_flag = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_valid, m_busy;
  logic [7:0]   m_data;

  always @(posedge CLK) begin
    bit cap, drop;
    logic [W-1:0] w;
    if (RST) begin
      mq.delete(); mb = 0; m_flag = 1'b0; m_ovf = 1'b0;
    end else begin
      cap = CMP_flag && !m_flag;
      m_flag = CMP_flag;
      drop = 0;
      if (mq.size() > 0 && TX_READY) begin
        mb++;
        if (mb == NB) begin void'(mq.pop_front()); mb = 0; end
      end
      if (cap) begin
        if (mq.size() < 2) mq.push_back(CMP_Out);
        else drop = 1;
      end
      m_ovf = drop ? 1'b1 : (CLR_OVF ? 1'b0 : m_ovf);
    end
    m_valid = (mq.size() > 0);
    m_busy  = m_valid;
    if (m_valid) begin w = mq[0] >> (8 * mb); m_data = w[7:0]; end
    else m_data = 8'h00;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick();
    n_chk++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", TX_VALID); end
    n_chk++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", TX_DATA); end
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    n_chk++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
    RST = 1'b0; tick();
  endtask

  task automatic test_single();
    CMP_Out = 16'h0003; CMP_flag = 1'b1; TX_READY = 1'b1;
    tick();
    n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h03) begin n_fail++; $display("FAIL single_b0 got=%b/%h exp=1/03", TX_VALID, TX_DATA); end
    tick();
    n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h00) begin n_fail++; $display("FAIL single_b1 got=%b/%h exp=1/00", TX_VALID, TX_DATA); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL single_idle%0d valid/busy=%b/%b exp=0/0", i, TX_VALID, BUSY); end
    end
    CMP_flag = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    TX_READY = 1'b0; CMP_Out = 16'hA55A; CMP_flag = 1'b1;
    tick();
    CMP_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL bp_stall%0d got=%b/%h exp=1/5a", i, TX_VALID, TX_DATA); end
      tick();
    end
    TX_READY = 1'b1;
    n_chk++; if (TX_DATA !== 8'h5A) begin n_fail++; $display("FAIL bp_b0 got=%h exp=5a", TX_DATA); end
    tick();
    n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hA5) begin n_fail++; $display("FAIL bp_b1 got=%b/%h exp=1/a5", TX_VALID, TX_DATA); end
    tick();
    n_chk++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_end valid=%b exp=0", TX_VALID); end
  endtask

  task automatic test_queued();
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h02; exp_b[3] = 8'h00;
    TX_READY = 1'b0; CMP_Out = 16'h0001; CMP_flag = 1'b1; tick();
    CMP_flag = 1'b0; tick();
    CMP_Out = 16'h0002; CMP_flag = 1'b1; tick();
    CMP_flag = 1'b0; TX_READY = 1'b1;
    n_chk++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL q_busy got=%b exp=1", BUSY); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== exp_b[i]) begin n_fail++; $display("FAIL q_b%0d got=%b/%h exp=1/%h", i, TX_VALID, TX_DATA, exp_b[i]); end
      tick();
    end
    n_chk++; if (TX_VALID !== 1'b0 || OVF !== 1'b0) begin n_fail++; $display("FAIL q_end valid/ovf=%b/%b exp=0/0", TX_VALID, OVF); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h02; exp_b[3] = 8'h00;
    TX_READY = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      CMP_Out = W'(i); CMP_flag = 1'b1; tick();
      CMP_flag = 1'b0; tick();
    end
    n_chk++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", OVF); end
    TX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== exp_b[i]) begin n_fail++; $display("FAIL ovf_b%0d got=%b/%h exp=1/%h", i, TX_VALID, TX_DATA, exp_b[i]); end
      tick();
    end
    n_chk++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovf_drained valid=%b exp=0", TX_VALID); end
    CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
    n_chk++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", OVF); end
    // Fill both slots, then drop a third in the same cycle CLR_OVF is high.
    TX_READY = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      CMP_Out = W'(i); CMP_flag = 1'b1;
      if (i == 7) CLR_OVF = 1'b1;
      tick();
      CMP_flag = 1'b0; CLR_OVF = 1'b0; tick();
    end
    n_chk++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=1", OVF); end
    CLR_OVF = 1'b1; TX_READY = 1'b1; tick(); CLR_OVF = 1'b0;
    for (int i = 0; i < 20 && TX_VALID; i++) tick();
    n_chk++; if (TX_VALID !== 1'b0 || OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_cleanup valid/ovf=%b/%b exp=0/0", TX_VALID, OVF); end
  endtask

  task automatic test_reset_mid();
    TX_READY = 1'b1; CMP_Out = 16'h1234; CMP_flag = 1'b1; tick();
    CMP_flag = 1'b0;
    n_chk++; if (TX_DATA !== 8'h34) begin n_fail++; $display("FAIL rst_b0 got=%h exp=34", TX_DATA); end
    tick();
    RST = 1'b1; tick(); RST = 1'b0;
    n_chk++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid/busy/ovf=%b/%b/%b exp=0/0/0", TX_VALID, BUSY, OVF); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_quiet%0d valid=%b data=%h exp valid=0", i, TX_VALID, TX_DATA); end
    end
  endtask

  task automatic test_last_byte_capture();
    TX_READY = 1'b1; CMP_Out = 16'h1111; CMP_flag = 1'b1; tick();
    CMP_flag = 1'b0; tick();
    CMP_Out = 16'h00FF; CMP_flag = 1'b1; tick();
    CMP_flag = 1'b0;
    n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'hFF) begin n_fail++; $display("FAIL lbc_b0 got=%b/%h exp=1/ff", TX_VALID, TX_DATA); end
    tick();
    n_chk++; if (TX_VALID !== 1'b1 || TX_DATA !== 8'h00) begin n_fail++; $display("FAIL lbc_b1 got=%b/%h exp=1/00", TX_VALID, TX_DATA); end
    tick();
    n_chk++; if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL lbc_end valid=%b exp=0", TX_VALID); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      RST      = ($urandom_range(0, 59) == 0);
      CMP_flag = ($urandom_range(0, 2) == 0) ? ~CMP_flag : CMP_flag;
      CMP_Out  = W'($urandom);
      TX_READY = ($urandom_range(0, 2) != 0);
      CLR_OVF  = ($urandom_range(0, 9) == 0);
      tick();
      n_chk++; if (TX_VALID !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, TX_VALID, m_valid); end
      n_chk++; if (TX_DATA !== m_data) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, TX_DATA, m_data); end
      n_chk++; if (BUSY !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, BUSY, m_busy); end
      n_chk++; if (OVF !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, OVF, m_ovf); end
    end
    RST = 1'b0; CMP_flag = 1'b0; CLR_OVF = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_queued();
    test_overflow();
    test_reset_mid();
    test_last_byte_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
